// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants for the FPU compare/classify sequencer.
//   - opcodes of the compare/classify group
//   - FSM state constants
//   - FP80 field positions and special exponent/mantissa values
//   - FXAM class encodings ({C3,C2,C0})
//   - fp_class_t: classifier result record
package fpu_pkg;

  localparam logic [7:0] OP_FCOM   = 8'h60;
  localparam logic [7:0] OP_FCOMP  = 8'h61;
  localparam logic [7:0] OP_FCOMPP = 8'h62;
  localparam logic [7:0] OP_FTST   = 8'h63;
  localparam logic [7:0] OP_FXAM   = 8'h64;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RDA  = 3'd1;
  localparam state_t ST_RDB  = 3'd2;
  localparam state_t ST_EVAL = 3'd3;
  localparam state_t ST_POP1 = 3'd4;
  localparam state_t ST_POP2 = 3'd5;
  localparam state_t ST_DONE = 3'd6;

  localparam int FP_SIGN    = 79;
  localparam int FP_EXP_HI  = 78;
  localparam int FP_EXP_LO  = 64;
  localparam int FP_MANT_HI = 63;
  localparam int FP_MANT_LO = 0;

  localparam logic [14:0] EXP_MAX  = 15'h7FFF;
  localparam logic [63:0] MANT_INF = 64'h8000_0000_0000_0000;

  localparam logic [2:0] CLS_UNSUP  = 3'b000;
  localparam logic [2:0] CLS_NAN    = 3'b001;
  localparam logic [2:0] CLS_NORMAL = 3'b010;
  localparam logic [2:0] CLS_INF    = 3'b011;
  localparam logic [2:0] CLS_ZERO   = 3'b100;
  localparam logic [2:0] CLS_EMPTY  = 3'b101;
  localparam logic [2:0] CLS_DENORM = 3'b110;

  // Compare results share the {C3,C2,C0} layout.
  localparam logic [2:0] REL_GT  = 3'b000;
  localparam logic [2:0] REL_LT  = 3'b001;
  localparam logic [2:0] REL_EQ  = 3'b100;
  localparam logic [2:0] REL_BAD = 3'b111;

  typedef struct packed {
    logic       sign;
    logic       is_nan;
    logic       is_inf;
    logic       is_zero;
    logic       is_denorm;
    logic       is_unnormal;
    logic [2:0] cls;
  } fp_class_t;

  function automatic logic is_group_op(input logic [7:0] op);
    return (op >= OP_FCOM) && (op <= OP_FXAM);
  endfunction

endpackage

// File: rtl/fpu_classify.sv
// fpu_classify: combinational FP80 operand classifier.
//   operand_i [79:0] : extended-precision operand
//   empty_i          : register tag says the slot is empty
//   class_o          : sign, NaN/inf/zero/denormal/unnormal flags and
//                      the FXAM class code (empty takes priority)
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [79:0] operand_i,
  input  logic        empty_i,
  output fp_class_t   class_o
);

  logic [14:0] exp_w;
  logic [63:0] mant_w;

  assign exp_w  = operand_i[FP_EXP_HI:FP_EXP_LO];
  assign mant_w = operand_i[FP_MANT_HI:FP_MANT_LO];

  always_comb begin
    class_o             = '0;
    class_o.sign        = operand_i[FP_SIGN];
    // Any max-exponent pattern other than the canonical infinity is a NaN,
    // which also covers the pseudo-infinity/pseudo-NaN encodings.
    class_o.is_nan      = (exp_w == EXP_MAX) && (mant_w != MANT_INF);
    class_o.is_inf      = (exp_w == EXP_MAX) && (mant_w == MANT_INF);
    class_o.is_zero     = (exp_w == 15'd0) && (mant_w == 64'd0);
    class_o.is_denorm   = (exp_w == 15'd0) && (mant_w != 64'd0);
    class_o.is_unnormal = (exp_w != 15'd0) && (exp_w != EXP_MAX) && !mant_w[63];

    if (empty_i)                  class_o.cls = CLS_EMPTY;
    else if (class_o.is_nan)      class_o.cls = CLS_NAN;
    else if (class_o.is_inf)      class_o.cls = CLS_INF;
    else if (class_o.is_zero)     class_o.cls = CLS_ZERO;
    else if (class_o.is_denorm)   class_o.cls = CLS_DENORM;
    else if (class_o.is_unnormal) class_o.cls = CLS_UNSUP;
    else                          class_o.cls = CLS_NORMAL;
  end

endmodule

// File: rtl/fpu_compare_sequencer.sv
// fpu_compare_sequencer: sequences FCOM/FCOMP/FCOMPP/FTST/FXAM.
//   execute/instruction/stack_index : start request from the decoder
//   ready / done / error            : handshake back to the decoder
//   stk_rd_en/idx, stk_rd_data/empty: register-stack read port (1-cycle data)
//   stk_pop                         : one pulse per stack pop
//   cc_out/cc_we, ie_flag, sf_flag  : status-word condition codes and flags
// IE_MASKED=1: invalid/underflow writes CC 111 and still pops.
// IE_MASKED=0: invalid/underflow skips CC write and pops, pulses error.
module fpu_compare_sequencer
  import fpu_pkg::*;
#(
  parameter bit IE_MASKED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        execute,
  input  logic [7:0]  instruction,
  input  logic [2:0]  stack_index,
  output logic        ready,
  output logic        done,
  output logic        error,
  output logic        stk_rd_en,
  output logic [2:0]  stk_rd_idx,
  input  logic [79:0] stk_rd_data,
  input  logic        stk_rd_empty,
  output logic        stk_pop,
  output logic [3:0]  cc_out,
  output logic        cc_we,
  output logic        ie_flag,
  output logic        sf_flag
);

  state_t      state_q, state_d;
  logic [7:0]  op_q;
  logic [2:0]  idx_q;
  logic [79:0] a_q;
  logic        a_empty_q;
  logic [3:0]  cc_q;
  logic        cc_we_q, ie_q, sf_q, err_q;

  logic        b_is_const, reads_b, is_cmp, needs_pop;
  logic [79:0] b_data;
  logic        b_empty;
  fp_class_t   ca, cb;
  logic        underflow, invalid, bad, suppress;
  logic [2:0]  rel;
  logic [3:0]  eval_cc;

  assign b_is_const = (op_q == OP_FTST) || (op_q == OP_FXAM);
  assign reads_b    = !b_is_const;
  assign is_cmp     = (op_q != OP_FXAM);
  assign needs_pop  = (op_q == OP_FCOMP) || (op_q == OP_FCOMPP);

  // FTST/FXAM never read B; it is a fixed +0.0 that is never empty.
  assign b_data  = b_is_const ? 80'd0 : stk_rd_data;
  assign b_empty = b_is_const ? 1'b0  : stk_rd_empty;

  fpu_classify u_class_a (.operand_i(a_q),    .empty_i(a_empty_q), .class_o(ca));
  fpu_classify u_class_b (.operand_i(b_data), .empty_i(b_empty),   .class_o(cb));

  logic unused_cls;
  assign unused_cls = &{1'b0, ca.is_inf, ca.is_denorm, cb.is_inf, cb.is_denorm, cb.cls};

  assign underflow = is_cmp && (a_empty_q || b_empty);
  assign invalid   = is_cmp && (ca.is_nan || ca.is_unnormal || cb.is_nan || cb.is_unnormal);
  assign bad       = underflow || invalid;
  assign suppress  = bad && !IE_MASKED;

  // Sign/magnitude ordering: the low 79 bits order monotonically within a sign.
  always_comb begin
    rel = REL_EQ;
    if (ca.is_zero && cb.is_zero)
      rel = REL_EQ;
    else if (ca.sign != cb.sign)
      rel = ca.sign ? REL_LT : REL_GT;
    else if (a_q[78:0] == b_data[78:0])
      rel = REL_EQ;
    else if ((a_q[78:0] > b_data[78:0]) ^ ca.sign)
      rel = REL_GT;
    else
      rel = REL_LT;
  end

  always_comb begin
    if (!is_cmp)  eval_cc = {ca.cls[2], ca.cls[1], ca.sign, ca.cls[0]};
    else if (bad) eval_cc = {REL_BAD[2], REL_BAD[1], 1'b0, REL_BAD[0]};
    else          eval_cc = {rel[2], rel[1], 1'b0, rel[0]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (execute && is_group_op(instruction)) state_d = ST_RDA;
      ST_RDA:  state_d = ST_RDB;
      ST_RDB:  state_d = ST_EVAL;
      ST_EVAL: begin
        if (suppress)       state_d = ST_DONE;
        else if (needs_pop) state_d = ST_POP1;
        else                state_d = ST_DONE;
      end
      ST_POP1: state_d = (op_q == OP_FCOMPP) ? ST_POP2 : ST_DONE;
      ST_POP2: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 8'd0;
      idx_q     <= 3'd0;
      a_q       <= 80'd0;
      a_empty_q <= 1'b0;
      cc_q      <= 4'd0;
      cc_we_q   <= 1'b0;
      ie_q      <= 1'b0;
      sf_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_we_q <= 1'b0;
      ie_q    <= 1'b0;
      sf_q    <= 1'b0;
      if (state_q == ST_IDLE && state_d == ST_RDA) begin
        op_q  <= instruction;
        idx_q <= stack_index;
      end
      if (state_q == ST_RDB) begin
        a_q       <= stk_rd_data;
        a_empty_q <= stk_rd_empty;
      end
      if (state_q == ST_EVAL) begin
        cc_we_q <= !suppress;
        ie_q    <= bad;
        sf_q    <= underflow;
        err_q   <= suppress;
        if (!suppress) cc_q <= eval_cc;
      end
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign error      = done && err_q;
  assign stk_rd_en  = (state_q == ST_RDA) || ((state_q == ST_RDB) && reads_b);
  assign stk_rd_idx = ((state_q == ST_RDB) && reads_b) ?
                      ((op_q == OP_FCOMPP) ? 3'd1 : idx_q) : 3'd0;
  assign stk_pop    = (state_q == ST_POP1) || (state_q == ST_POP2);
  assign cc_out     = cc_q;
  assign cc_we      = cc_we_q;
  assign ie_flag    = ie_q;
  assign sf_flag    = sf_q;

endmodule
